mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache and dcache; one-cycle arbitration, requester stalled via iwait/dwait.
// dcache owns two-word blocks atomically; icache is forced in after STARVE_LIMIT consecutive dcache blocks.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ramready
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, DBUS, IBUS} state_t;

   state_t        state, state_nxt;
   logic          lock, lock_nxt;
   logic [CW-1:0] starve_cnt, starve_nxt, starve_inc;
   logic          dreq;

   assign dreq  = dREN | dWEN;
   assign iload = ramload;
   assign dload = ramload;
   assign starve_inc = (starve_cnt == CW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;

   function automatic state_t arbitrate(input logic i_req, input logic d_req,
                                        input logic [CW-1:0] cnt);
      state_t res;
      if (i_req && cnt == CW'(STARVE_LIMIT)) res = IBUS;
      else if (d_req)                        res = DBUS;
      else if (i_req)                        res = IBUS;
      else                                   res = IDLE;
      return res;
   endfunction

   // Burst end counts toward starvation, and the updated count decides the re-arbitration.
   always_comb begin
      starve_nxt = starve_cnt;
      if (!iREN)
         starve_nxt = '0;
      else if (state == IBUS && ramready)
         starve_nxt = '0;
      else if (state == DBUS && dreq && ramready && daddr[2])
         starve_nxt = starve_inc;
   end

   always_comb begin
      state_nxt = state;
      lock_nxt  = lock;
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      ramaddr   = '0;
      ramstore  = '0;
      iwait     = 1'b1;
      dwait     = 1'b1;
      case (state)
         IDLE: begin
            lock_nxt  = 1'b0;
            state_nxt = arbitrate(iREN, dreq, starve_cnt);
         end
         DBUS: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            dwait    = ~ramready;
            if (!dreq) begin
               state_nxt = IDLE;
               lock_nxt  = 1'b0;
            end else if (ramready) begin
               if (!daddr[2]) begin
                  lock_nxt = 1'b1;
               end else begin
                  lock_nxt  = 1'b0;
                  state_nxt = arbitrate(iREN, dreq, starve_nxt);
               end
            end
         end
         IBUS: begin
            ramaddr = iaddr;
            ramREN  = 1'b1;
            iwait   = ~ramready;
            if (!iREN)
               state_nxt = IDLE;
            else if (ramready)
               state_nxt = dreq ? DBUS : IBUS;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         lock       <= 1'b0;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         lock       <= lock_nxt;
         starve_cnt <= starve_nxt;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against an ownership-level reference model.
module tb_mem_arbiter;
   localparam int LIMIT = 4;
   localparam int OWN_NONE = 0, OWN_D = 1, OWN_I = 2;

   logic        CLK, nRST;
   logic        iREN, dREN, dWEN, ramready;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic        iwait, dwait, ramREN, ramWEN;

   int total = 0, passed = 0;

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramready(ramready)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: who owns the RAM, whether a block is half done, and how many
   // dcache blocks have finished while icache kept asking.
   int m_owner = OWN_NONE;
   int m_waited = 0;
   bit m_lock = 1'b0;

   function automatic int pick(input int waited);
      int r;
      if (iREN && waited >= LIMIT) r = OWN_I;
      else if (dREN || dWEN)      r = OWN_D;
      else if (iREN)              r = OWN_I;
      else                        r = OWN_NONE;
      return r;
   endfunction

   always @(posedge CLK or negedge nRST) begin
      int w;
      if (!nRST) begin
         m_owner = OWN_NONE; m_lock = 1'b0; m_waited = 0;
      end else begin
         w = iREN ? m_waited : 0;
         if (m_owner == OWN_NONE) begin
            m_owner = pick(m_waited);
         end else if (m_owner == OWN_D) begin
            if (!(dREN || dWEN)) begin
               m_owner = OWN_NONE; m_lock = 1'b0;
            end else if (ramready) begin
               if (!daddr[2]) m_lock = 1'b1;
               else begin
                  m_lock = 1'b0;
                  w = iREN ? ((m_waited + 1 > LIMIT) ? LIMIT : m_waited + 1) : 0;
                  m_owner = pick(w);
               end
            end
         end else begin
            if (!iREN) m_owner = OWN_NONE;
            else if (ramready) begin
               w = 0;
               m_owner = (dREN || dWEN) ? OWN_D : OWN_I;
            end
         end
         m_waited = w;
      end
   end

   always @(negedge CLK) begin
      logic [31:0] e_addr, e_store;
      logic e_ren, e_wen, e_iw, e_dw;
      e_addr = '0; e_store = '0; e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
      if (m_owner == OWN_D) begin
         e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN && !dWEN; e_dw = !ramready;
      end else if (m_owner == OWN_I) begin
         e_addr = iaddr; e_ren = 1'b1; e_iw = !ramready;
      end
      chk("cmp_ramREN", ramREN, e_ren);
      chk("cmp_ramWEN", ramWEN, e_wen);
      chk("cmp_ramaddr", ramaddr, e_addr);
      chk("cmp_ramstore", ramstore, e_store);
      chk("cmp_iwait", iwait, e_iw);
      chk("cmp_dwait", dwait, e_dw);
      chk("cmp_iload", iload, ramload);
      chk("cmp_dload", dload, ramload);
      chk("cmp_lock", dut.lock, m_lock);
      chk("cmp_starve", 32'(dut.starve_cnt), m_waited);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic idle_inputs();
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
   endtask

   initial begin
      bit half, got;
      int words;
      nRST = 1'b0;
      iREN = 1'b1; dREN = 1'b0; dWEN = 1'b1; ramready = 1'b1;
      iaddr = 32'h44; daddr = 32'hDEAD; dstore = 32'hBEEF; ramload = 32'h0;

      // Reset holds idle outputs even with both requesters asking
      @(negedge CLK);
      chk("rst_ramREN", ramREN, 0);
      chk("rst_ramWEN", ramWEN, 0);
      chk("rst_ramaddr", ramaddr, 0);
      chk("rst_ramstore", ramstore, 0);
      chk("rst_iwait", iwait, 1);
      chk("rst_dwait", dwait, 1);
      step(); idle_inputs(); nRST = 1'b1;
      step(); step();

      // Block lock: first word done, second word stalls, icache stays out
      dWEN = 1'b1; daddr = 32'h200; dstore = 32'h11112222; ramready = 1'b1;
      iREN = 1'b1; iaddr = 32'h500;
      step();
      @(negedge CLK);
      chk("blk_w0_wen", ramWEN, 1);
      chk("blk_w0_addr", ramaddr, 32'h200);
      chk("blk_w0_dwait", dwait, 0);
      step(); daddr = 32'h204; ramready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("blk_hold_wen", ramWEN, 1);
         chk("blk_hold_addr", ramaddr, 32'h204);
         chk("blk_hold_iwait", iwait, 1);
         chk("blk_hold_dwait", dwait, 1);
         step();
      end
      ramready = 1'b1;
      @(negedge CLK);
      chk("blk_w1_dwait", dwait, 0);
      chk("blk_w1_iwait", iwait, 1);
      step();
      @(negedge CLK);
      chk("blk_end_lock", dut.lock, 0);
      chk("blk_end_starve", 32'(dut.starve_cnt), 1);
      step(); idle_inputs(); step(); step();

      // Reset mid-block drops the strobe at once; regrant after release
      dWEN = 1'b1; daddr = 32'h300; ramready = 1'b1;
      step();
      step(); ramready = 1'b0;
      @(negedge CLK);
      chk("mid_lock", dut.lock, 1);
      #1 nRST = 1'b0;
      #1;
      chk("mid_rst_wen", ramWEN, 0);
      chk("mid_rst_dwait", dwait, 1);
      dWEN = 1'b0; dREN = 1'b1;
      step(); nRST = 1'b1;
      @(negedge CLK);
      chk("mid_rel_idle", ramREN, 0);
      @(negedge CLK);
      chk("mid_rel_ren", ramREN, 1);
      chk("mid_rel_addr", ramaddr, 32'h300);
      step(); idle_inputs(); step(); step();

      // Icache only with two stall cycles
      iREN = 1'b1; iaddr = 32'h40; ramload = 32'hCAFE0040;
      step();
      for (int k = 0; k < 3; k++) begin
         ramready = (k == 2);
         @(negedge CLK);
         chk("ic_ren", ramREN, 1);
         chk("ic_addr", ramaddr, 32'h40);
         chk("ic_iwait", iwait, (k == 2) ? 0 : 1);
         if (k == 2) chk("ic_iload", iload, 32'hCAFE0040);
         step();
      end
      idle_inputs(); step(); step();

      // Starvation: four dcache blocks, then icache gets one access
      half = 1'b0; got = 1'b0; words = 0;
      dWEN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h80; ramready = 1'b1;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge CLK);
         if (iwait == 1'b0) got = 1'b1;
         else if (dwait == 1'b0) begin words++; half = !half; end
         if (!got) begin
            step();
            daddr = 32'h100 | {29'd0, half, 2'b00};
         end
      end
      chk("starve_grant", got, 1);
      chk("starve_words", words, 2 * LIMIT);
      step();
      @(negedge CLK);
      chk("starve_clear", 32'(dut.starve_cnt), 0);
      chk("starve_back_d", dwait, 0);

      // Abort mid-block, icache granted the cycle after idle
      step(); dWEN = 1'b0;
      @(negedge CLK);
      chk("abort_lock_pre", dut.lock, 1);
      @(negedge CLK);
      chk("abort_idle_wen", ramWEN, 0);
      chk("abort_idle_iwait", iwait, 1);
      chk("abort_lock", dut.lock, 0);
      @(negedge CLK);
      chk("abort_ibus_iwait", iwait, 0);
      chk("abort_ibus_addr", ramaddr, 32'h80);
      step(); idle_inputs(); step(); step();

      // Random traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         step();
         nRST = ($urandom_range(0, 99) >= 2);
         if ($urandom_range(0, 9) == 0) iREN = ~iREN;
         if ($urandom_range(0, 6) == 0) begin
            dREN = $urandom_range(0, 1) == 1;
            dWEN = $urandom_range(0, 2) == 0;
         end
         daddr    = $urandom & 32'h3FC;
         iaddr    = $urandom & 32'hFFC;
         dstore   = $urandom;
         ramload  = $urandom;
         ramready = $urandom_range(0, 99) < 70;
      end
      step(); nRST = 1'b1; idle_inputs(); step(); step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
